// File: rtl/fetch_sched_pkg.sv
// Purpose: shared constants and FSM encoding for the fetch scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: RESET_PC default, ADEF exception code, scheduler state encoding.
// Optional feature macro: FETCH_ADEF_EN (adds the HALT state).
package fetch_sched_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h1c00_0000;
    localparam logic [3:0]  EXCP_ADEF        = 4'h8;

`ifdef FETCH_ADEF_EN
    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1
    } state_t;
`endif

endpackage

// File: rtl/fetch_fifo.sv
// Purpose: small synchronous FIFO with a synchronous clear, head shown combinationally.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: push ignored when full, pop ignored when empty; the caller bounds occupancy.
// Ports: clk/reset (sync, active-low), clear (drop all entries), push/push_dat,
//        pop, head_dat (zero while empty), empty, full.
module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] head_dat,
    output logic             empty,
    output logic             full
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    // Zero while empty so downstream sees a clean value after reset and flush.
    assign head_dat = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wr_ptr[AW-1:0]] <= push_dat;
    end

endmodule

// File: rtl/fetch_sched.sv
// Purpose: fetch address generator / icache issue / address-instruction pairing for IF.
// Latency: accepted request at T shows vaddr at T+1; response at T shows inst at T+1.
// Backpressure: req_valid drops once MAX_OUT entries (live + to-be-discarded) are pending.
// Ports: clk, reset (sync, active-low); excp/ertn/br flush + targets; icache req_valid/
//        req_addr/req_ready and rsp_valid/rsp_inst; IF head vaddr/vaddr_valid/inst/
//        inst_valid/excp_o/excp_num_o and is_fire (consume head).
// Optional feature macro: FETCH_ADEF_EN (misaligned-PC fetch exception + HALT).
module fetch_sched
    import fetch_sched_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          MAX_OUT  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        excp_flush,
    input  logic [31:0] excp_entry,
    input  logic        ertn_flush,
    input  logic [31:0] era,
    input  logic        br_flush,
    input  logic [31:0] br_target,
    output logic        req_valid,
    output logic [31:0] req_addr,
    input  logic        req_ready,
    input  logic        rsp_valid,
    input  logic [31:0] rsp_inst,
    output logic [31:0] vaddr,
    output logic        vaddr_valid,
    output logic [31:0] inst,
    output logic        inst_valid,
    output logic        excp_o,
    output logic [3:0]  excp_num_o,
    input  logic        is_fire
);

    localparam int              CW      = $clog2(MAX_OUT + 1) + 1;
    localparam logic [CW-1:0]   MAX_CNT = CW'(MAX_OUT);
`ifdef FETCH_ADEF_EN
    localparam int AFW = 33;   // {excp flag, address}
`else
    localparam int AFW = 32;
`endif

    state_t          state_q, state_d;
    logic [31:0]     pc_q;
    logic [CW-1:0]   out_q;    // issued (or pseudo-entry) not yet consumed by IF
    logic [CW-1:0]   infl_q;   // accepted by icache, response still owed, not squashed
    logic [CW-1:0]   disc_q;   // responses owed to squashed requests

    logic            flush;
    logic [31:0]     flush_tgt;
    logic            room;
    logic            acc;
    logic            adef_issue;
    logic            fire;
    logic            rsp_keep;
    logic            rsp_drop;
    logic            push_a;
    logic            push_i;
    logic [AFW-1:0]  a_push_dat;
    logic [AFW-1:0]  a_head;
    logic [31:0]     i_push_dat;
    logic            a_empty, a_full;
    logic            i_empty, i_full;

    assign flush     = excp_flush | ertn_flush | br_flush;
    assign flush_tgt = excp_flush ? excp_entry : (ertn_flush ? era : br_target);

    // Squashed responses still occupy icache slots, so they count against the bound.
    assign room = (out_q + disc_q) < MAX_CNT;

    always_comb begin
        state_d    = state_q;
        req_valid  = 1'b0;
        adef_issue = 1'b0;
        case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN: begin
`ifdef FETCH_ADEF_EN
                if (pc_q[1:0] != 2'b00) begin
                    // Wait until all real responses are back so the zero
                    // pseudo-instruction lands behind them in order.
                    adef_issue = room && (infl_q == '0);
                    if (adef_issue)
                        state_d = ST_HALT;
                end else begin
                    req_valid = room;
                end
`else
                req_valid = room;
`endif
            end
`ifdef FETCH_ADEF_EN
            ST_HALT: state_d = ST_HALT;
`endif
            default: state_d = ST_BOOT;
        endcase
        if (flush)
            state_d = ST_RUN;
    end

    always_ff @(posedge clk) begin
        if (!reset)
            state_q <= ST_BOOT;
        else
            state_q <= state_d;
    end

    assign acc      = req_valid & req_ready;
    assign fire     = is_fire & ~flush;
    assign rsp_keep = rsp_valid & (disc_q == '0);
    assign rsp_drop = rsp_valid & (disc_q != '0);

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q   <= RESET_PC;
            out_q  <= '0;
            infl_q <= '0;
            disc_q <= '0;
        end else if (flush) begin
            pc_q   <= flush_tgt;
            out_q  <= '0;
            infl_q <= '0;
            // Everything still owed by the icache, including a request accepted
            // this very cycle, minus a response arriving this cycle.
            disc_q <= disc_q + infl_q + CW'(acc) - CW'(rsp_valid);
        end else begin
            if (acc)
                pc_q <= pc_q + 32'd4;
            out_q  <= out_q + CW'(push_a) - CW'(fire);
            infl_q <= infl_q + CW'(acc) - CW'(rsp_keep);
            disc_q <= disc_q - CW'(rsp_drop);
        end
    end

    assign push_a     = acc | adef_issue;
    assign push_i     = rsp_keep | adef_issue;
    assign i_push_dat = adef_issue ? 32'h0 : rsp_inst;
`ifdef FETCH_ADEF_EN
    assign a_push_dat = {adef_issue, pc_q};
`else
    assign a_push_dat = pc_q;
`endif

    fetch_fifo #(.WIDTH(AFW), .DEPTH(MAX_OUT)) u_addr_fifo (
        .clk      (clk),
        .reset    (reset),
        .clear    (flush),
        .push     (push_a),
        .push_dat (a_push_dat),
        .pop      (fire),
        .head_dat (a_head),
        .empty    (a_empty),
        .full     (a_full)
    );

    fetch_fifo #(.WIDTH(32), .DEPTH(MAX_OUT)) u_inst_fifo (
        .clk      (clk),
        .reset    (reset),
        .clear    (flush),
        .push     (push_i),
        .push_dat (i_push_dat),
        .pop      (fire),
        .head_dat (inst),
        .empty    (i_empty),
        .full     (i_full)
    );

    assign req_addr    = pc_q;
    assign vaddr       = a_head[31:0];
    assign vaddr_valid = ~a_empty;
    assign inst_valid  = ~i_empty;
`ifdef FETCH_ADEF_EN
    assign excp_o      = a_head[32];
    assign excp_num_o  = a_head[32] ? EXCP_ADEF : 4'h0;
`else
    assign excp_o      = 1'b0;
    assign excp_num_o  = 4'h0;
`endif

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (reset && fire)
            assert (!a_empty && !i_empty)
                else $error("fetch_sched: is_fire while head pair incomplete");
        if (reset && !flush && push_a)
            assert (!a_full) else $error("fetch_sched: address fifo overflow");
        if (reset && !flush && push_i)
            assert (!i_full) else $error("fetch_sched: instruction fifo overflow");
    end
`endif

endmodule

// File: tb/tb_fetch_sched.sv
// Purpose: directed self-checking bench for fetch_sched (MAX_OUT=2).
// Latency: inputs driven 1 time unit after each rising edge, outputs checked there.
// Backpressure: icache emulated by hand (req_ready / rsp_valid driven per step).
module tb_fetch_sched;

    logic        clk;
    logic        reset;
    logic        excp_flush;
    logic [31:0] excp_entry;
    logic        ertn_flush;
    logic [31:0] era;
    logic        br_flush;
    logic [31:0] br_target;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_inst;
    logic [31:0] vaddr;
    logic        vaddr_valid;
    logic [31:0] inst;
    logic        inst_valid;
    logic        excp_o;
    logic [3:0]  excp_num_o;
    logic        is_fire;

    int n_vec = 0;
    int n_err = 0;
    int acc_cnt;
    int k;
    logic auto_rsp;

    fetch_sched #(.RESET_PC(32'h1c00_0000), .MAX_OUT(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .excp_flush  (excp_flush),
        .excp_entry  (excp_entry),
        .ertn_flush  (ertn_flush),
        .era         (era),
        .br_flush    (br_flush),
        .br_target   (br_target),
        .req_valid   (req_valid),
        .req_addr    (req_addr),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_inst    (rsp_inst),
        .vaddr       (vaddr),
        .vaddr_valid (vaddr_valid),
        .inst        (inst),
        .inst_valid  (inst_valid),
        .excp_o      (excp_o),
        .excp_num_o  (excp_num_o),
        .is_fire     (is_fire)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout, required $finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    // One cycle with an icache that answers each accepted request in the next cycle.
    task automatic cyc();
        logic        a;
        logic [31:0] ad;
        a  = req_valid & req_ready;
        ad = req_addr;
        tick();
        rsp_valid = auto_rsp & a;
        rsp_inst  = ~ad;
        if (a) acc_cnt++;
    endtask

    task automatic do_reset();
        reset      = 1'b0;
        excp_flush = 1'b0;
        ertn_flush = 1'b0;
        br_flush   = 1'b0;
        excp_entry = 32'h0;
        era        = 32'h0;
        br_target  = 32'h0;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        rsp_inst   = 32'h0;
        is_fire    = 1'b0;
        auto_rsp   = 1'b0;
        acc_cnt    = 0;
        tick();
        tick();
        reset = 1'b1;
        tick();   // BOOT -> RUN
    endtask

    initial begin
        // ---- reset values ----
        reset = 1'b0; excp_flush = 0; ertn_flush = 0; br_flush = 0;
        excp_entry = 0; era = 0; br_target = 0; req_ready = 0;
        rsp_valid = 0; rsp_inst = 0; is_fire = 0; auto_rsp = 0;
        tick();
        tick();
        chk("rst_req_valid",   32'(req_valid),   32'd0);
        chk("rst_req_addr",    req_addr,         32'h1c00_0000);
        chk("rst_vaddr_valid", 32'(vaddr_valid), 32'd0);
        chk("rst_inst_valid",  32'(inst_valid),  32'd0);
        chk("rst_excp_o",      32'(excp_o),      32'd0);
        chk("rst_excp_num",    32'(excp_num_o),  32'd0);
        chk("rst_vaddr",       vaddr,            32'h0);
        chk("rst_inst",        inst,             32'h0);
        reset = 1'b1;
        tick();
        chk("boot_to_run_req_valid", 32'(req_valid), 32'd1);

        // ---- 1: streaming, fire whenever the head pair is ready ----
        do_reset();
        req_ready = 1'b1;
        auto_rsp  = 1'b1;
        k = 0;
        for (int c = 0; c < 20 && k < 3; c++) begin
            is_fire = vaddr_valid & inst_valid;
            if (is_fire) begin
                chk("stream_vaddr", vaddr, 32'h1c00_0000 + 32'(k * 4));
                chk("stream_inst",  inst,  ~(32'h1c00_0000 + 32'(k * 4)));
                k++;
            end
            cyc();
        end
        is_fire = 1'b0;
        chk("stream_count", 32'(k), 32'd3);

        // ---- 2: IF stalled, at most MAX_OUT requests ----
        do_reset();
        chk("rerst_vaddr_valid", 32'(vaddr_valid), 32'd0);
        req_ready = 1'b1;
        auto_rsp  = 1'b1;
        repeat (6) cyc();
        chk("stall_acc_cnt",   32'(acc_cnt),   32'd2);
        chk("stall_req_valid", 32'(req_valid), 32'd0);
        chk("stall_vaddr",     vaddr,          32'h1c00_0000);
        chk("stall_inst",      inst,           ~32'h1c00_0000);
        is_fire = 1'b1;
        cyc();
        is_fire = 1'b0;
        chk("unstall_req_valid", 32'(req_valid), 32'd1);
        chk("unstall_req_addr",  req_addr,       32'h1c00_0008);
        chk("unstall_vaddr",     vaddr,          32'h1c00_0004);
        chk("unstall_inst",      inst,           ~32'h1c00_0004);

        // ---- 3: branch flush with two unanswered requests ----
        do_reset();
        chk("rerst_req_addr", req_addr, 32'h1c00_0000);
        req_ready = 1'b1;
        tick();
        tick();
        chk("br_pre_req_valid", 32'(req_valid), 32'd0);
        br_flush  = 1'b1;
        br_target = 32'h1c00_0100;
        tick();
        br_flush  = 1'b0;
        req_ready = 1'b0;
        chk("br_req_valid_held", 32'(req_valid),   32'd0);
        chk("br_req_addr",       req_addr,         32'h1c00_0100);
        chk("br_vaddr_valid",    32'(vaddr_valid), 32'd0);
        rsp_valid = 1'b1; rsp_inst = 32'hdead_0001;
        tick();
        chk("br_drop1_inst_valid", 32'(inst_valid), 32'd0);
        chk("br_drop1_req_valid",  32'(req_valid),  32'd1);
        rsp_inst = 32'hdead_0002;
        tick();
        rsp_valid = 1'b0;
        chk("br_drop2_inst_valid", 32'(inst_valid), 32'd0);
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        chk("br_new_vaddr_valid", 32'(vaddr_valid), 32'd1);
        chk("br_new_vaddr",       vaddr,            32'h1c00_0100);
        chk("br_new_inst_valid",  32'(inst_valid),  32'd0);
        rsp_valid = 1'b1; rsp_inst = 32'hcafe_0100;
        tick();
        rsp_valid = 1'b0;
        chk("br_new_inst_valid2", 32'(inst_valid), 32'd1);
        chk("br_new_inst",        inst,            32'hcafe_0100);
        is_fire = 1'b1;
        tick();
        is_fire = 1'b0;
        chk("br_pop_vaddr_valid", 32'(vaddr_valid), 32'd0);

        // ---- 4: flush target priority and pc wrap ----
        excp_flush = 1'b1; excp_entry = 32'h1c00_8000;
        br_flush   = 1'b1; br_target  = 32'h1c00_0200;
        tick();
        excp_flush = 1'b0; br_flush = 1'b0;
        chk("prio_excp_req_addr",  req_addr,       32'h1c00_8000);
        chk("prio_excp_req_valid", 32'(req_valid), 32'd1);
        ertn_flush = 1'b1; era = 32'h1c00_a000;
        br_flush   = 1'b1;
        tick();
        ertn_flush = 1'b0; br_flush = 1'b0;
        chk("prio_ertn_req_addr", req_addr, 32'h1c00_a000);
        br_flush = 1'b1; br_target = 32'hffff_fffc;
        tick();
        br_flush  = 1'b0;
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        chk("wrap_req_addr", req_addr, 32'h0000_0000);
        chk("wrap_vaddr",    vaddr,    32'hffff_fffc);

        // ---- 5: flush together with a response and a new acceptance ----
        do_reset();
        req_ready = 1'b1;
        tick();                              // A0 accepted
        rsp_valid = 1'b1; rsp_inst = 32'h1111_0000;  // answer for A0
        br_flush  = 1'b1; br_target = 32'h1c00_0300; // A4 accepted this cycle
        tick();
        br_flush = 1'b0; rsp_valid = 1'b0; req_ready = 1'b0;
        chk("cofl_vaddr_valid", 32'(vaddr_valid), 32'd0);
        chk("cofl_inst_valid",  32'(inst_valid),  32'd0);
        chk("cofl_req_addr",    req_addr,         32'h1c00_0300);
        chk("cofl_req_valid",   32'(req_valid),   32'd1);
        req_ready = 1'b1;
        rsp_valid = 1'b1; rsp_inst = 32'hbad0_0004;  // stale answer for A4
        tick();
        req_ready = 1'b0; rsp_valid = 1'b0;
        chk("cofl_new_vaddr",      vaddr,           32'h1c00_0300);
        chk("cofl_stale_dropped",  32'(inst_valid), 32'd0);
        chk("cofl_new_req_valid",  32'(req_valid),  32'd1);
        rsp_valid = 1'b1; rsp_inst = 32'h600d_0300;
        tick();
        rsp_valid = 1'b0;
        chk("cofl_good_inst_valid", 32'(inst_valid), 32'd1);
        chk("cofl_good_inst",       inst,            32'h600d_0300);

`ifdef FETCH_ADEF_EN
        // ---- 6: misaligned fetch address ----
        do_reset();
        req_ready  = 1'b1;
        excp_flush = 1'b1; excp_entry = 32'h1c00_0002;
        tick();
        excp_flush = 1'b0;
        chk("adef_no_req", 32'(req_valid), 32'd0);
        tick();
        chk("adef_vaddr_valid", 32'(vaddr_valid), 32'd1);
        chk("adef_vaddr",       vaddr,            32'h1c00_0002);
        chk("adef_excp_o",      32'(excp_o),      32'd1);
        chk("adef_excp_num",    32'(excp_num_o),  32'h8);
        chk("adef_inst_valid",  32'(inst_valid),  32'd1);
        chk("adef_inst",        inst,             32'h0);
        chk("adef_halt_req",    32'(req_valid),   32'd0);
        is_fire = 1'b1;
        tick();
        is_fire = 1'b0;
        tick();
        chk("adef_halt_req2",   32'(req_valid),   32'd0);
        chk("adef_popped",      32'(vaddr_valid), 32'd0);
        br_flush = 1'b1; br_target = 32'h1c00_0400;
        tick();
        br_flush = 1'b0;
        chk("adef_resume_req",  32'(req_valid),   32'd1);
        chk("adef_resume_addr", req_addr,         32'h1c00_0400);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_sched.md
# fetch_sched

Fetch-side scheduler sitting between the PC, the instruction cache and the IF check/latch stage. Generates sequential fetch addresses, issues them to the icache with a bounded number of requests in flight, and pairs returning instructions with their addresses for the IF stage. On flush it redirects the PC and silently discards responses belonging to squashed requests.

## Interface
- RESET_PC, 32'h1c00_0000, first fetch address after reset
- MAX_OUT, 2, max requests issued but not yet consumed by IF stage (power of two, 2..8)
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- excp_flush  in  1  exception redirect
- excp_entry  in  32  exception target
- ertn_flush  in  1  ertn redirect
- era  in  32  ertn target
- br_flush  in  1  branch-mispredict redirect
- br_target  in  32  branch target
- req_valid  out  1  icache request
- req_addr  out  32  icache request address
- req_ready  in  1  icache accepts request
- rsp_valid  in  1  icache instruction returned (in order, one per accepted request)
- rsp_inst  in  32  returned instruction
- vaddr  out  32  head address to IF stage
- vaddr_valid  out  1  head address valid
- inst  out  32  head instruction to IF stage
- inst_valid  out  1  head instruction valid
- excp_o  out  1  head entry carries fetch exception
- excp_num_o  out  4  exception code
- is_fire  in  1  IF stage consumed head pair

## Operation
- pc register, reset to RESET_PC. req_valid = (state==RUN) & (outstanding < MAX_OUT). Request handshake (req_valid & req_ready): push pc into address FIFO, outstanding+1, pc <= pc+4 (32-bit wrap).
- Address FIFO and instruction FIFO, each MAX_OUT deep. Non-discarded rsp_valid pushes rsp_inst into instruction FIFO. vaddr/vaddr_valid = address FIFO head/not-empty; inst/inst_valid = instruction FIFO head/not-empty.
- is_fire pops both FIFOs, outstanding-1. is_fire with either FIFO empty is a protocol error (assertion).
- outstanding bounds both FIFOs; overflow impossible by construction.
- Flush: any of excp_flush/ertn_flush/br_flush. Target priority excp_entry > era > br_target. At the flush edge: pc <= target, both FIFOs cleared, outstanding <= 0, discard <= (requests accepted but unanswered, including one accepted in the flush cycle) minus (rsp_valid in the flush cycle). An is_fire in the flush cycle is ignored.
- While discard>0, rsp_valid decrements discard and is dropped. Counter width $clog2(MAX_OUT+1)+1. New requests allowed the cycle after flush; req_valid additionally held low while outstanding+discard >= MAX_OUT.
- FSM: BOOT (reset state, one cycle, req_valid=0) -> RUN. No other states unless the macro below is defined.

## Timing
- Reset values: req_valid=0, req_addr=RESET_PC, vaddr_valid=0, inst_valid=0, excp_o=0, excp_num_o=0, vaddr=0, inst=0.
- req_addr is the pc register (no comb path from flush inputs).
- Accepted request at cycle T: earliest vaddr_valid at T+1; inst_valid the cycle after rsp_valid.
- Flush at T: req_valid may assert at T+1 with req_addr=target.
- Reset mid-operation clears everything; responses in flight after reset are not tracked (icache reset together).

## Configuration
- FETCH_ADEF_EN defined: pc[1:0]!=0 at issue produces no icache request; a pseudo-entry is pushed (address FIFO, inst=32'h0 in instruction FIFO, excp flag set, excp_num_o=ADEF code), FSM enters HALT (req_valid=0) until a flush. excp_o/excp_num_o travel with the address FIFO entry.
- Undefined: no alignment check, excp_o/excp_num_o tied 0, no HALT state.

## Structure
- Shared package: ADEF excp code, RESET_PC default, FSM state encoding.
- One sub-module fetch_fifo (parameterised width/depth, sync clear), instantiated twice.

## Test plan
- Reset release, req_ready=1, rsp one cycle later, is_fire every cycle -> addresses 1c000000,1c000004,1c000008 in order, inst matches.
- is_fire held 0 -> exactly MAX_OUT=2 requests issued, then req_valid=0 until first is_fire.
- Two requests outstanding, br_flush target 1c000100 -> next two rsp_valid dropped, next req_addr 1c000100, next vaddr 1c000100.
- excp_flush and br_flush same cycle (excp_entry 1c008000, br_target 1c000200) -> req_addr 1c008000.
- Flush coinciding with rsp_valid and a new request acceptance -> discard counts correctly, no stale inst reaches IF stage.
- FETCH_ADEF_EN, excp_flush to 1c000002 -> no icache request, excp_o=1 with ADEF code at vaddr 1c000002, req_valid stays 0 until next flush.
